// File: rtl/dpwm_gen_frecuencia.sv
// DPWM base square-wave generator: 2^n-scaled half period from a
// resynchronised frequency index, applied only on period boundaries.
module dpwm_gen_frecuencia #(
  parameter int HALF_BASE = 5,
  parameter int CNT_W     = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] numero_frec,
  output logic       clk_pwm,
  output logic       tick,
  output logic [2:0] frec_activa,
  output logic       cambio_pendiente
);

  generate
    if ((1 << CNT_W) <= HALF_BASE * 128) begin : g_cnt_w_chk
      $error("CNT_W too narrow for HALF_BASE << 7");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ALTO = 2'd1,
    BAJO = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BASE = CNT_W'(HALF_BASE);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_sync1;
  logic [2:0]       r_idx_s;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pwm;
  logic             r_tick;
  logic [2:0]       r_frec;
  logic             r_cambio;

  logic [CNT_W-1:0] w_half;
  logic             w_fin;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pwm_nxt;
  logic             w_tick_nxt;
  logic [2:0]       w_frec_nxt;

  // Half period follows the index in effect, never the incoming one
  assign w_half = BASE << r_frec;
  assign w_fin  = (r_cnt == (w_half - ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_idx_s <= '0;
    end else begin
      r_sync1 <= numero_frec;
      r_idx_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (enable) w_state_nxt = ALTO;
      ALTO: if (w_fin) w_state_nxt = BAJO;
      BAJO: if (w_fin) w_state_nxt = enable ? ALTO : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt  = r_cnt + ONE;
    w_pwm_nxt  = 1'b0;
    w_tick_nxt = 1'b0;
    w_frec_nxt = r_frec;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (enable) begin
          w_pwm_nxt  = 1'b1;
          w_tick_nxt = 1'b1;
          w_frec_nxt = r_idx_s;
        end
      end
      ALTO: begin
        if (w_fin) begin
          w_cnt_nxt = '0;
        end else begin
          w_pwm_nxt = 1'b1;
        end
      end
      BAJO: begin
        if (w_fin) begin
          w_cnt_nxt = '0;
          if (enable) begin
            w_pwm_nxt  = 1'b1;
            w_tick_nxt = 1'b1;
            w_frec_nxt = r_idx_s;
          end
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_pwm    <= 1'b0;
      r_tick   <= 1'b0;
      r_frec   <= '0;
      r_cambio <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_pwm    <= w_pwm_nxt;
      r_tick   <= w_tick_nxt;
      r_frec   <= w_frec_nxt;
      r_cambio <= (r_idx_s != r_frec);
    end
  end

  assign clk_pwm          = r_pwm;
  assign tick             = r_tick;
  assign frec_activa      = r_frec;
  assign cambio_pendiente = r_cambio;

endmodule

// File: tb/tb_dpwm_gen_frecuencia.sv
// Directed bench for dpwm_gen_frecuencia: period lengths, boundary-only
// index loading, enable drop, wide index and async reset.
module tb_dpwm_gen_frecuencia;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [2:0] numero_frec;
  logic       clk_pwm;
  logic       tick;
  logic [2:0] frec_activa;
  logic       cambio_pendiente;

  int n_chk;
  int n_err;

  localparam int LIM = 3000;

  dpwm_gen_frecuencia #(
    .HALF_BASE(5),
    .CNT_W    (12)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .numero_frec     (numero_frec),
    .clk_pwm         (clk_pwm),
    .tick            (tick),
    .frec_activa     (frec_activa),
    .cambio_pendiente(cambio_pendiente)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < LIM);
  endtask

  task automatic meas_half(output int hi, output int lo);
    hi = 0;
    lo = 0;
    while (clk_pwm && hi < LIM) begin
      hi++;
      step();
    end
    while (!clk_pwm && lo < LIM) begin
      lo++;
      step();
    end
  endtask

  int hi, lo, n, c, busy;

  initial begin
    n_chk       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    numero_frec = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pwm", clk_pwm, 0);
    chk("rst_tick", tick, 0);
    chk("rst_frec", frec_activa, 0);
    chk("rst_camb", cambio_pendiente, 0);
    rst_n = 1'b1;
    repeat (3) step();

    // idx 0: 5 high / 5 low
    enable = 1'b1;
    step();
    chk("t1_tick", tick, 1);
    chk("t1_pwm", clk_pwm, 1);
    chk("t1_frec", frec_activa, 0);
    meas_half(hi, lo);
    chk("t1_hi", hi, 5);
    chk("t1_lo", lo, 5);
    chk("t1_tick2", tick, 1);

    // change to 3 mid-period
    step();
    chk("t2_tick_w", tick, 0);
    numero_frec = 3'd3;
    c = 0;
    do begin
      step();
      c++;
    end while (!cambio_pendiente && c < 10);
    chk("t2_camb_lat", c, 3);
    wait_tick(n);
    chk("t2_per0", 1 + c + n, 10);
    chk("t2_frec", frec_activa, 3);
    chk("t2_camb_ld", cambio_pendiente, 1);
    step();
    chk("t2_camb_clr", cambio_pendiente, 0);
    wait_tick(n);
    chk("t2_rest", n, 79);
    meas_half(hi, lo);
    chk("t2_hi", hi, 40);
    chk("t2_lo", lo, 40);

    // 3 -> 4 -> 2 inside one period
    repeat (5) step();
    numero_frec = 3'd4;
    repeat (10) step();
    numero_frec = 3'd2;
    step();
    chk("t3_hold", frec_activa, 3);
    wait_tick(n);
    chk("t3_rest", n, 64);
    chk("t3_frec", frec_activa, 2);
    meas_half(hi, lo);
    chk("t3_hi", hi, 20);
    chk("t3_lo", lo, 20);

    // enable drop at cycle 10 of a 40-cycle high half
    numero_frec = 3'd3;
    wait_tick(n);
    chk("t4_per2", n, 40);
    chk("t4_frec", frec_activa, 3);
    repeat (9) step();
    enable = 1'b0;
    step();
    hi = 0;
    while (clk_pwm && hi < LIM) begin
      hi++;
      step();
    end
    chk("t4_hi_rem", hi, 30);
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      if (clk_pwm || tick) busy++;
      step();
    end
    chk("t4_idle", busy, 0);
    enable = 1'b1;
    step();
    chk("t4_restart", tick, 1);
    meas_half(hi, lo);
    chk("t4_hi", hi, 40);
    chk("t4_lo", lo, 40);

    // idx 7: 640 / 640, then back to 0 at the boundary
    numero_frec = 3'd7;
    wait_tick(n);
    chk("t5_per3", n, 80);
    chk("t5_frec", frec_activa, 7);
    meas_half(hi, lo);
    chk("t5_hi", hi, 640);
    chk("t5_lo", lo, 640);
    numero_frec = 3'd0;
    repeat (1000) step();
    chk("t5_hold", frec_activa, 7);
    chk("t5_mid_pwm", clk_pwm, 0);
    wait_tick(n);
    chk("t5_rest", n, 280);
    chk("t5_frec0", frec_activa, 0);

    // async reset mid-low half at idx 5
    numero_frec = 3'd5;
    wait_tick(n);
    chk("t6_per0", n, 10);
    chk("t6_frec", frec_activa, 5);
    repeat (100) step();
    numero_frec = 3'd6;
    repeat (100) step();
    chk("t6_pre_pwm", clk_pwm, 0);
    chk("t6_pre_camb", cambio_pendiente, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pwm", clk_pwm, 0);
    chk("t6_rst_tick", tick, 0);
    chk("t6_rst_frec", frec_activa, 0);
    chk("t6_rst_camb", cambio_pendiente, 0);
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (clk_pwm || tick) busy++;
    end
    chk("t6_quiet", busy, 0);
    enable = 1'b1;
    step();
    chk("t6_tick", tick, 1);
    chk("t6_frec6", frec_activa, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
